// File: rtl/maquina_bebidas_param.sv
// ============================================================================
// Module   : maquina_bebidas_param
// Purpose  : Parametrised multi-channel beverage dispenser controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maquina_bebidas_param #(
  parameter int N_CH   = 2,
  parameter int DOSE_W = 8,
  parameter int STEP   = 25,
  parameter int CNT_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   inicio,
  input  logic                                   cancelar,
  input  logic [N_CH*DOSE_W-1:0]                 doses,
  output logic [N_CH-1:0]                        valvula,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] canal,
  output logic [DOSE_W-1:0]                      volume,
  output logic                                   ocupado,
  output logic                                   pronto,
  output logic                                   abortado,
  output logic                                   erro,
  output logic [CNT_W-1:0]                       copos
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DOSE_W:0] C_STEP = (DOSE_W+1)'(STEP);

  localparam logic [1:0] ST_ESPERA   = 2'd0;
  localparam logic [1:0] ST_ENCHENDO = 2'd1;
  localparam logic [1:0] ST_PRONTO   = 2'd2;

  logic [DOSE_W-1:0] w_dose_in [N_CH];
  logic [DOSE_W-1:0] r_dose    [N_CH];
  logic [1:0]        r_state;
  logic [CW-1:0]     r_canal;
  logic [DOSE_W-1:0] r_volume;
  logic [CNT_W-1:0]  r_copos;
  logic              r_erro;
  logic              r_abortado;

  logic              w_any_in;
  logic [CW-1:0]     w_first_ch;
  logic              w_has_next;
  logic [CW-1:0]     w_next_ch;
  logic [DOSE_W-1:0] w_cur_dose;
  logic [DOSE_W:0]   w_rem;
  logic [DOSE_W:0]   w_inc;
  logic [DOSE_W:0]   w_vol_sum;
  logic              w_last;
  logic [N_CH-1:0]   w_valvula;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign w_dose_in[gi] = doses[gi*DOSE_W +: DOSE_W];
  end

  // Lowest nonzero channel on the port: descending scan so the smallest index wins.
  always_comb begin
    w_any_in   = 1'b0;
    w_first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_dose_in[i] != '0) begin
        w_any_in   = 1'b1;
        w_first_ch = CW'(i);
      end
    end
  end

  always_comb begin
    w_has_next = 1'b0;
    w_next_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if ((CW'(i) > r_canal) && (r_dose[i] != '0)) begin
        w_has_next = 1'b1;
        w_next_ch  = CW'(i);
      end
    end
  end

  // Increment is clipped to the remainder; one extra bit keeps the sum exact.
  always_comb begin
    w_cur_dose = r_dose[r_canal];
    w_rem      = {1'b0, w_cur_dose} - {1'b0, r_volume};
    w_inc      = (w_rem < C_STEP) ? w_rem : C_STEP;
    w_vol_sum  = {1'b0, r_volume} + w_inc;
    w_last     = (w_vol_sum == {1'b0, w_cur_dose});
  end

  always_comb begin
    w_valvula = '0;
    if (r_state == ST_ENCHENDO) begin
      w_valvula[r_canal] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ESPERA;
      r_canal    <= '0;
      r_volume   <= '0;
      r_copos    <= '0;
      r_erro     <= 1'b0;
      r_abortado <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_dose[i] <= '0;
      end
    end else begin
      r_erro     <= 1'b0;
      r_abortado <= 1'b0;
      case (r_state)
        ST_ESPERA: begin
          if (inicio) begin
            for (int i = 0; i < N_CH; i++) begin
              r_dose[i] <= w_dose_in[i];
            end
            if (!w_any_in) begin
              r_erro <= 1'b1;
            end else begin
              r_canal  <= w_first_ch;
              r_volume <= '0;
              r_state  <= ST_ENCHENDO;
            end
          end
        end
        ST_ENCHENDO: begin
          // Cancel takes priority over any fill progress on the same edge.
          if (cancelar) begin
            r_state    <= ST_ESPERA;
            r_volume   <= '0;
            r_canal    <= '0;
            r_abortado <= 1'b1;
          end else if (w_last) begin
            r_volume <= '0;
            if (w_has_next) begin
              r_canal <= w_next_ch;
            end else begin
              r_canal <= '0;
              r_state <= ST_PRONTO;
              r_copos <= r_copos + 1'b1;
            end
          end else begin
            r_volume <= w_vol_sum[DOSE_W-1:0];
          end
        end
        ST_PRONTO: begin
          r_state <= ST_ESPERA;
        end
        default: begin
          r_state <= ST_ESPERA;
        end
      endcase
    end
  end

  // Reported volume includes the increment being dispensed in the current cycle.
  assign volume   = (r_state == ST_ENCHENDO) ? w_vol_sum[DOSE_W-1:0] : '0;
  assign valvula  = w_valvula;
  assign canal    = r_canal;
  assign ocupado  = (r_state == ST_ENCHENDO) || (r_state == ST_PRONTO);
  assign pronto   = (r_state == ST_PRONTO);
  assign erro     = r_erro;
  assign abortado = r_abortado;
  assign copos    = r_copos;

endmodule

`default_nettype wire
